// File: rtl/mux_pkg.sv
// Shared constants for the N:1 stream selector: operating modes and the
// ceiling-log2 helper used to size channel indices.
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: rotate the request vector so that ptr sits
// at position 0, then take the lowest set bit and map it back to a channel.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    logic [N-1:0] w_rot;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch can never be inferred.
        w_rot     = '0;
        gnt_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_rot[k] = req[(int'(ptr) + k) % N];
        end
        gnt_valid = |w_rot;
        // Scan from the far end so the position nearest ptr is written last.
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                gnt_idx = SEL_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/stream_mux_nx1.sv
// N:1 valid/ready stream selector with a single registered output stage.
// The channel is picked by the external sel or by a fair round-robin arbiter.
module stream_mux_nx1
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = clog2(N),
    parameter int MODE  = MODE_SEL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   cur_sel
);

    logic             w_chosen_valid;
    logic [SEL_W-1:0] w_chosen_idx;
    logic             w_can_load;
    logic             w_transfer;
    logic [WIDTH-1:0] w_load_data;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_cur_sel;

    assign w_can_load = !r_out_valid || out_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] r_rr_ptr;
            logic             w_unused_sel;

            assign w_unused_sel = ^sel;

            rr_arbiter #(
                .N     (N),
                .SEL_W (SEL_W)
            ) u_arb (
                .req       (in_valid),
                .ptr       (r_rr_ptr),
                .gnt_valid (w_chosen_valid),
                .gnt_idx   (w_chosen_idx)
            );

            // The pointer only advances on a transfer, which bounds the wait of any held request.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rr_ptr <= '0;
                end else if (w_transfer) begin
                    r_rr_ptr <= (w_chosen_idx == SEL_W'(N - 1)) ? '0 : w_chosen_idx + SEL_W'(1);
                end
            end
        end else begin : g_sel
            assign w_chosen_valid = (int'(sel) < N);
            assign w_chosen_idx   = sel;
        end
    endgenerate

    // Decoding by equality keeps an out-of-range sel from ever indexing past N.
    always_comb begin
        in_ready    = '0;
        w_transfer  = 1'b0;
        w_load_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_chosen_valid && (w_chosen_idx == SEL_W'(i)) && w_can_load) begin
                in_ready[i] = 1'b1;
                w_transfer  = in_valid[i];
                w_load_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_cur_sel   <= '0;
        end else if (w_transfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_load_data;
            r_cur_sel   <= w_chosen_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign cur_sel   = r_cur_sel;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Scoreboard bench for stream_mux_nx1: three instances (select N=4,
// round-robin N=4, select N=3) driven by directed vectors.
module tb_stream_mux_nx1;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    logic [31:0] a_in_data;
    logic [3:0]  a_in_valid, a_in_ready;
    logic [1:0]  a_sel, a_cur_sel;
    logic [7:0]  a_out_data;
    logic        a_out_valid, a_out_ready;

    logic [31:0] b_in_data;
    logic [3:0]  b_in_valid, b_in_ready;
    logic [1:0]  b_sel, b_cur_sel;
    logic [7:0]  b_out_data;
    logic        b_out_valid, b_out_ready;

    logic [23:0] c_in_data;
    logic [2:0]  c_in_valid, c_in_ready;
    logic [1:0]  c_sel, c_cur_sel;
    logic [7:0]  c_out_data;
    logic        c_out_valid, c_out_ready;

    stream_mux_nx1 #(.WIDTH(8), .N(4), .MODE(0)) u_sel4 (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .cur_sel(a_cur_sel)
    );

    stream_mux_nx1 #(.WIDTH(8), .N(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .cur_sel(b_cur_sel)
    );

    stream_mux_nx1 #(.WIDTH(8), .N(3), .MODE(0)) u_sel3 (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .cur_sel(c_cur_sel)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic extra_word(input string name, input logic [7:0] data);
        checks++;
        errors++;
        $display("FAIL %s: unexpected output word %0h with nothing expected", name, data);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a word is consumed when valid and ready are both seen mid-cycle.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                extra_word("A_extra", a_out_data);
            end else begin
                e = qa.pop_front();
                check("A_data", 32'(a_out_data), 32'(e.data));
                check("A_sel", 32'(a_cur_sel), 32'(e.sel));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                extra_word("B_extra", b_out_data);
            end else begin
                e = qb.pop_front();
                check("B_data", 32'(b_out_data), 32'(e.data));
                check("B_sel", 32'(b_cur_sel), 32'(e.sel));
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (rst_n && c_out_valid && c_out_ready) begin
            if (qc.size() == 0) begin
                extra_word("C_extra", c_out_data);
            end else begin
                e = qc.pop_front();
                check("C_data", 32'(c_out_data), 32'(e.data));
                check("C_sel", 32'(c_cur_sel), 32'(e.sel));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] nxt;
        logic       m_valid;
        logic       can_load;

        a_in_data = '0; a_in_valid = '0; a_sel = '0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_valid = '0; b_sel = '0; b_out_ready = 1'b0;
        c_in_data = '0; c_in_valid = '0; c_sel = '0; c_out_ready = 1'b0;

        // Reset state.
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(a_out_valid), 0);
        check("rst_data", 32'(a_out_data), 0);
        check("rst_sel", 32'(a_cur_sel), 0);
        check("rst_valid_b", 32'(b_out_valid), 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Select mode: sel=2 moves A5 with one cycle of latency.
        a_sel = 2'd2;
        a_in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        a_in_valid = 4'b0101;
        a_out_ready = 1'b1;
        #1;
        check("sel_ready", 32'(a_in_ready), 32'h4);
        qa.push_back('{sel: 2'd2, data: 8'hA5});
        step();
        a_in_valid = '0;
        check("sel_valid", 32'(a_out_valid), 1);

        // Ready follows sel even when that channel is idle.
        a_sel = 2'd3;
        #1;
        check("ready_no_valid", 32'(a_in_ready), 32'h8);
        step();

        // Stall: the held word and its index stay put while inputs churn.
        a_sel = 2'd1;
        a_in_data = {8'h00, 8'h00, 8'h3C, 8'h00};
        a_in_valid = 4'b0010;
        a_out_ready = 1'b0;
        qa.push_back('{sel: 2'd1, data: 8'h3C});
        step();
        for (int k = 0; k < 5; k++) begin
            a_sel = 2'(k);
            a_in_valid = 4'b1111;
            a_in_data = 32'hC0C1C2C3 + 32'(k);
            #1;
            check("stall_ready", 32'(a_in_ready), 0);
            check("stall_data", 32'(a_out_data), 32'h3C);
            check("stall_sel", 32'(a_cur_sel), 1);
            step();
        end
        a_sel = 2'd3;
        a_in_data = {8'h77, 8'h00, 8'h00, 8'h00};
        a_in_valid = 4'b1000;
        a_out_ready = 1'b1;
        #1;
        check("release_ready", 32'(a_in_ready), 32'h8);
        qa.push_back('{sel: 2'd3, data: 8'h77});
        step();
        a_in_valid = '0;
        step();

        // Back-to-back: eight words on channel 1, one per cycle.
        for (int i = 0; i < 8; i++) begin
            a_sel = 2'd1;
            a_in_data = {8'h00, 8'h00, 8'(i), 8'h00};
            a_in_valid = 4'b0010;
            qa.push_back('{sel: 2'd1, data: 8'(i)});
            step();
            check("b2b_valid", 32'(a_out_valid), 1);
        end
        a_in_valid = '0;
        step();
        step();
        check("b2b_drained", 32'(a_out_valid), 0);

        // Random consumer back-pressure on channel 2, reference model tracks can_load.
        nxt = 8'h80;
        m_valid = 1'b0;
        a_sel = 2'd2;
        a_in_valid = 4'b0100;
        for (int k = 0; k < 24; k++) begin
            a_out_ready = 1'($urandom_range(0, 1));
            a_in_data = {8'h00, nxt, 8'h00, 8'h00};
            can_load = !m_valid || a_out_ready;
            #1;
            check("bp_ready", 32'(a_in_ready), can_load ? 32'h4 : 32'h0);
            if (can_load) begin
                qa.push_back('{sel: 2'd2, data: nxt});
                nxt = nxt + 8'd1;
                m_valid = 1'b1;
            end
            step();
        end
        a_in_valid = '0;
        a_out_ready = 1'b1;
        step();
        step();
        check("bp_drained", 32'(a_out_valid), 0);

        // Asynchronous reset while a word is held: dropped without a clock edge.
        a_sel = 2'd0;
        a_in_data = {8'h00, 8'h00, 8'h00, 8'h5A};
        a_in_valid = 4'b0001;
        a_out_ready = 1'b0;
        qa.push_back('{sel: 2'd0, data: 8'h5A});
        step();
        a_in_valid = '0;
        check("pre_rst_valid", 32'(a_out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(a_out_valid), 0);
        check("async_rst_data", 32'(a_out_data), 0);
        check("async_rst_sel", 32'(a_cur_sel), 0);
        void'(qa.pop_back());
        step();
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        step();

        // Round-robin: all channels valid -> 0,1,2,3,0,1,2,3.
        b_in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        b_in_valid = 4'b1111;
        b_out_ready = 1'b1;
        b_sel = 2'd2;
        #1;
        check("rr_first_ready", 32'(b_in_ready), 32'h1);
        for (int k = 0; k < 8; k++) begin
            qb.push_back('{sel: 2'(k % 4), data: 8'(8'h10 + k % 4)});
            step();
        end
        b_in_valid = '0;
        step();

        // Round-robin with channels 3 and 1 only -> 1,3,1,3.
        b_in_data = {8'h23, 8'h22, 8'h21, 8'h20};
        b_in_valid = 4'b1010;
        #1;
        check("rr_odd_ready", 32'(b_in_ready), 32'h2);
        qb.push_back('{sel: 2'd1, data: 8'h21});
        qb.push_back('{sel: 2'd3, data: 8'h23});
        qb.push_back('{sel: 2'd1, data: 8'h21});
        qb.push_back('{sel: 2'd3, data: 8'h23});
        for (int k = 0; k < 4; k++) begin
            step();
        end
        b_in_valid = '0;
        #1;
        check("rr_idle_ready", 32'(b_in_ready), 0);
        step();
        step();

        // N=3: sel at N-1 transfers, sel=N blocks everything.
        c_in_data = {8'h43, 8'h42, 8'h41};
        c_in_valid = 3'b111;
        c_out_ready = 1'b1;
        c_sel = 2'd0;
        qc.push_back('{sel: 2'd0, data: 8'h41});
        step();
        c_sel = 2'd3;
        #1;
        check("oor_ready", 32'(c_in_ready), 0);
        step();
        check("oor_valid_fall", 32'(c_out_valid), 0);
        check("oor_sel_hold", 32'(c_cur_sel), 0);
        check("oor_data_hold", 32'(c_out_data), 32'h41);
        step();
        check("oor_still_idle", 32'(c_out_valid), 0);
        c_sel = 2'd2;
        c_in_valid = 3'b100;
        qc.push_back('{sel: 2'd2, data: 8'h43});
        step();
        c_in_valid = '0;
        step();
        step();

        // Nothing expected may be left behind.
        check("A_left", 32'(qa.size()), 0);
        check("B_left", 32'(qb.size()), 0);
        check("C_left", 32'(qc.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
